// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC predictor.
//   ctr_t        : 2-bit branch direction counter encoding (SNT/WNT/WT/ST)
//   PC_RESET_VEC : default PC after reset
//   ctr_update   : next counter value for a resolved branch that hits the BTB
package pc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

    // Saturating up/down counter. Unconditional transfers pin the counter
    // at strongly-taken.
    function automatic ctr_t ctr_update(input ctr_t cur, input logic taken,
                                        input logic is_jump);
        if (is_jump)
            return ST;
        if (taken)
            return (cur == ST) ? ST : ctr_t'(cur + 2'd1);
        return (cur == SNT) ? SNT : ctr_t'(cur - 2'd1);
    endfunction

endpackage

// File: rtl/pc_predict_if.sv
// Fetch-side bus between the front end and the PC predictor.
//   stall, redirect_valid/redirect_pc : PC control from the pipeline
//   upd_*                             : one resolved control transfer per cycle
//   pc, pred_taken, pred_target       : current fetch PC and its prediction
// master: pipeline side (drives control/update, reads PC).
// slave : predictor side.
interface pc_predict_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic            upd_is_jump;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    modport master (
        output stall, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
        input  pc, pred_taken, pred_target
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
        output pc, pred_taken, pred_target
    );

endinterface

// File: rtl/pc_predict_btb.sv
// Direct-mapped branch target buffer.
//   clk, rst      : clock, synchronous active-high reset (clears valid+counters)
//   lookup_pc     : PC being fetched
//   pred_taken    : hit and (jump or counter >= WT), combinational
//   pred_target   : stored target when predicted taken, else lookup_pc+4
//   upd_*         : resolved control transfer to train the table
// Index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]. Lookups read the stored
// entry only, so a same-cycle update becomes visible on the next cycle.
module btb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BTB_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_is_jump
);

    localparam int unsigned IDX  = $clog2(BTB_DEPTH);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic            valid_q  [BTB_DEPTH];
    logic [TAGW-1:0] tag_q    [BTB_DEPTH];
    logic [XLEN-1:0] target_q [BTB_DEPTH];
    logic            jump_q   [BTB_DEPTH];
    ctr_t            ctr_q    [BTB_DEPTH];

    logic [IDX-1:0]  l_idx;
    logic [TAGW-1:0] l_tag;
    logic            l_hit;
    logic [IDX-1:0]  u_idx;
    logic [TAGW-1:0] u_tag;
    logic            u_hit;

    // Byte offset bits are not part of index or tag.
    logic unused_offset;
    assign unused_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[XLEN-1:IDX+2];
    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX+2];

    always_comb begin
        l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken  = l_hit && (jump_q[l_idx] || (ctr_q[l_idx] >= WT));
        pred_target = pred_taken ? target_q[l_idx] : lookup_pc + XLEN'(4);
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= SNT;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_update(ctr_q[u_idx], upd_taken, upd_is_jump);
                if (upd_taken) begin
                    target_q[u_idx] <= upd_target;
                    jump_q[u_idx]   <= upd_is_jump;
                end
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                jump_q[u_idx]   <= upd_is_jump;
                ctr_q[u_idx]    <= upd_is_jump ? ST : WT;
            end
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with BTB-based next-PC prediction.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pc_predict_if.slave (stall, redirect, BTB update, pc/prediction)
//   perf_fetch, perf_redirect : saturating event counters, present only when
//                               PC_PREDICT_PERF_EN is defined
// Next-PC priority: rst, redirect, stall, predicted target, pc+4.
module pc_predict
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     BTB_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC)
) (
    input  logic        clk,
    input  logic        rst,
    pc_predict_if.slave bus
`ifdef PC_PREDICT_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_redirect
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bus.upd_valid),
        .upd_pc      (bus.upd_pc),
        .upd_target  (bus.upd_target),
        .upd_taken   (bus.upd_taken),
        .upd_is_jump (bus.upd_is_jump)
    );

    // pred_target already falls back to pc+4 on a not-taken prediction.
    always_comb begin
        pc_d = pred_target;
        if (bus.redirect_valid)
            pc_d = bus.redirect_pc;
        else if (bus.stall)
            pc_d = pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_q <= RESET_VEC;
        else
            pc_q <= pc_d;
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

`ifdef PC_PREDICT_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch    <= '0;
            perf_redirect <= '0;
        end else if (bus.redirect_valid) begin
            if (perf_redirect != '1)
                perf_redirect <= perf_redirect + 32'd1;
        end else if (!bus.stall) begin
            if (perf_fetch != '1)
                perf_fetch <= perf_fetch + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict (XLEN=32, BTB_DEPTH=8, RESET_VEC=0).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_pc_predict;

    logic clk;
    logic rst;
    int unsigned n_total;
    int unsigned n_pass;

    pc_predict_if #(.XLEN(32)) bus ();

`ifdef PC_PREDICT_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_redirect;
`endif

    pc_predict #(
        .XLEN      (32),
        .BTB_DEPTH (8),
        .RESET_VEC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef PC_PREDICT_PERF_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_redirect (perf_redirect)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_target     = '0;
        bus.upd_taken      = 1'b0;
        bus.upd_is_jump    = 1'b0;
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] t,
                       input logic taken, input logic jump);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = p;
        bus.upd_target  = t;
        bus.upd_taken   = taken;
        bus.upd_is_jump = jump;
    endtask

    task automatic redirect_to(input logic [31:0] p);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = p;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        idle();

        // Reset release: 0, 4, 8, 12
        rst = 1'b1;
        step();
        step();
        check("reset_pc", bus.pc, 64'h0);
        check("reset_pred", bus.pred_taken, 64'h0);
        rst = 1'b0;
        step();
        check("seq_pc4", bus.pc, 64'h4);
        step();
        check("seq_pc8", bus.pc, 64'h8);
        step();
        check("seq_pc12", bus.pc, 64'hC);
        check("seq_pred", bus.pred_taken, 64'h0);

        // Allocation of 0x10 -> 0x40 while fetching 0xC
        upd(32'h10, 32'h40, 1'b1, 1'b0);
        step();
        idle();
        check("alloc_pc", bus.pc, 64'h10);
        check("alloc_pred", bus.pred_taken, 64'h1);
        check("alloc_tgt", bus.pred_target, 64'h40);
        step();
        check("alloc_follow", bus.pc, 64'h40);

        // Hysteresis: two not-taken updates, counter 2->1->0
        upd(32'h10, 32'h0, 1'b0, 1'b0);
        step();
        step();
        idle();
        check("hyst_pc", bus.pc, 64'h48);
        redirect_to(32'h10);
        check("hyst_pred", bus.pred_taken, 64'h0);
        check("hyst_tgt", bus.pred_target, 64'h14);
        step();
        check("hyst_follow", bus.pc, 64'h14);

        // Same-cycle lookup and update of the same index uses the old entry
        redirect_to(32'h10);
        upd(32'h10, 32'h80, 1'b1, 1'b0);
        check("bypass_pred", bus.pred_taken, 64'h0);
        step();
        idle();
        check("bypass_pc", bus.pc, 64'h14);

        // Redirect beats stall, then stall holds
        bus.stall = 1'b1;
        redirect_to(32'h200);
        check("prio_redir", bus.pc, 64'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold%0d", i), bus.pc, 64'h200);
        end
        bus.stall = 1'b0;
        redirect_to(32'h202);
        check("redir_unaligned", bus.pc, 64'h202);

        // Jump allocation at 0x08 -> 0x300
        upd(32'h08, 32'h300, 1'b1, 1'b1);
        step();
        idle();
        check("jump_pc", bus.pc, 64'h206);
        redirect_to(32'h08);
        check("jump_pred", bus.pred_taken, 64'h1);
        check("jump_tgt", bus.pred_target, 64'h300);
        step();
        check("jump_follow", bus.pc, 64'h300);

        // Aliasing: 0x30 shares index 4 with 0x10 and replaces it
        upd(32'h30, 32'h50, 1'b1, 1'b0);
        step();
        idle();
        redirect_to(32'h10);
        check("alias_miss", bus.pred_taken, 64'h0);
        check("alias_miss_tgt", bus.pred_target, 64'h14);
        redirect_to(32'h30);
        check("alias_hit", bus.pred_taken, 64'h1);
        check("alias_hit_tgt", bus.pred_target, 64'h50);

        // Wrap of pc+4
        redirect_to(32'hFFFF_FFFC);
        check("wrap_pc", bus.pc, 64'hFFFF_FFFC);
        check("wrap_tgt", bus.pred_target, 64'h0);
        step();
        check("wrap_next", bus.pc, 64'h0);

        // Reset during operation with coincident update and redirect
        rst = 1'b1;
        upd(32'h18, 32'h600, 1'b1, 1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h500;
        step();
        rst = 1'b0;
        idle();
        check("rst_op_pc", bus.pc, 64'h0);
`ifdef PC_PREDICT_PERF_EN
        check("rst_perf_fetch", perf_fetch, 64'h0);
        check("rst_perf_redir", perf_redirect, 64'h0);
`endif
        redirect_to(32'h30);
        check("rst_inv_30", bus.pred_taken, 64'h0);
        redirect_to(32'h08);
        check("rst_inv_08", bus.pred_taken, 64'h0);
        redirect_to(32'h18);
        check("rst_discard_18", bus.pred_taken, 64'h0);
`ifdef PC_PREDICT_PERF_EN
        check("perf_redir_cnt", perf_redirect, 64'h3);
        check("perf_fetch_cnt", perf_fetch, 64'h0);
        step();
        check("perf_fetch_inc", perf_fetch, 64'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
